// File: rtl/pos_input_ring_node_buf_pkg.sv
// ============================================================================
// Module  : pos_input_ring_node_buf_pkg
// Brief   : Widths, ring slot struct and cell-hit helpers for the position ring.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pos_input_ring_node_buf_pkg;

    localparam int GLOBAL_CELL_ID_WIDTH    = 3;
    localparam int GCID_WIDTH              = 3 * GLOBAL_CELL_ID_WIDTH;
    localparam int OFFSET_PKT_STRUCT_WIDTH = 24;
    localparam int NODE_ID_WIDTH           = 4;
    localparam int NB_CELL_COUNT_WIDTH     = 4;
    localparam int POS_PKT_STRUCT_WIDTH    = GCID_WIDTH + OFFSET_PKT_STRUCT_WIDTH;

    typedef struct packed {
        logic [OFFSET_PKT_STRUCT_WIDTH-1:0] offset_pkt;
        logic [GCID_WIDTH-1:0]              gcid;
        logic [NODE_ID_WIDTH-1:0]           node_id;
        logic [NB_CELL_COUNT_WIDTH-1:0]     lifetime;
    } pos_ring_slot_t;

    localparam int POS_RING_SLOT_WIDTH = $bits(pos_ring_slot_t);

    // A source cell is a target when it is the home cell or its +1 neighbour
    // in every dimension (modulo the global grid).
    function automatic logic check_pos_input_ring_target_hit(
        input logic [GCID_WIDTH-1:0]           src_gcid,
        input logic [GLOBAL_CELL_ID_WIDTH-1:0] home_x,
        input logic [GLOBAL_CELL_ID_WIDTH-1:0] home_y,
        input logic [GLOBAL_CELL_ID_WIDTH-1:0] home_z
    );
        logic [GLOBAL_CELL_ID_WIDTH-1:0] dx, dy, dz;
        dx = src_gcid[GLOBAL_CELL_ID_WIDTH-1:0] - home_x;
        dy = src_gcid[2*GLOBAL_CELL_ID_WIDTH-1:GLOBAL_CELL_ID_WIDTH] - home_y;
        dz = src_gcid[3*GLOBAL_CELL_ID_WIDTH-1:2*GLOBAL_CELL_ID_WIDTH] - home_z;
        return (dx[GLOBAL_CELL_ID_WIDTH-1:1] == '0) &&
               (dy[GLOBAL_CELL_ID_WIDTH-1:1] == '0) &&
               (dz[GLOBAL_CELL_ID_WIDTH-1:1] == '0);
    endfunction

    function automatic logic [GCID_WIDTH-1:0] compute_nb_cid(
        input logic [GCID_WIDTH-1:0]           src_gcid,
        input logic [GLOBAL_CELL_ID_WIDTH-1:0] home_x,
        input logic [GLOBAL_CELL_ID_WIDTH-1:0] home_y,
        input logic [GLOBAL_CELL_ID_WIDTH-1:0] home_z
    );
        logic [GLOBAL_CELL_ID_WIDTH-1:0] dx, dy, dz;
        dx = src_gcid[GLOBAL_CELL_ID_WIDTH-1:0] - home_x;
        dy = src_gcid[2*GLOBAL_CELL_ID_WIDTH-1:GLOBAL_CELL_ID_WIDTH] - home_y;
        dz = src_gcid[3*GLOBAL_CELL_ID_WIDTH-1:2*GLOBAL_CELL_ID_WIDTH] - home_z;
        return {dz, dy, dx};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pos_input_ring_node_buf_fifo.sv
// ============================================================================
// Module  : md_sync_fifo
// Brief   : Show-ahead synchronous FIFO; a push on a full FIFO lands if it pops.
// Revision: 1.0
// ============================================================================
`default_nettype none

module md_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/pos_input_ring_node_buf.sv
// ============================================================================
// Module  : pos_input_ring_node_buf
// Brief   : Buffered position-input ring node: PE delivery and local injection.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pos_input_ring_node_buf
    import pos_input_ring_node_buf_pkg::*;
#(
    parameter int NUM_FOLDS      = 1,
    parameter int NUM_CELL_FOLDS = NUM_FOLDS,
    parameter logic [NUM_CELL_FOLDS-1:0][GLOBAL_CELL_ID_WIDTH-1:0] GCELL_X = '0,
    parameter logic [NUM_CELL_FOLDS-1:0][GLOBAL_CELL_ID_WIDTH-1:0] GCELL_Y = '0,
    parameter logic [NUM_CELL_FOLDS-1:0][GLOBAL_CELL_ID_WIDTH-1:0] GCELL_Z = '0,
    parameter int LOCAL_FIFO_DEPTH   = 8,
    parameter int PE_FIFO_DEPTH      = 4,
    parameter int LOCAL_AFULL_MARGIN = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [OFFSET_PKT_STRUCT_WIDTH-1:0] i_source_offset_pkt,
    input  logic [GCID_WIDTH-1:0]              i_source_gcid,
    input  logic [NODE_ID_WIDTH-1:0]           i_source_node_id,
    input  logic [NB_CELL_COUNT_WIDTH-1:0]     i_source_lifetime,
    input  logic [OFFSET_PKT_STRUCT_WIDTH-1:0] i_local_offset_pkt,
    input  logic [GCID_WIDTH-1:0]              i_local_gcid,
    input  logic [NODE_ID_WIDTH-1:0]           i_local_node_id,
    input  logic [NB_CELL_COUNT_WIDTH-1:0]     i_local_lifetime,
    input  logic                               i_local_valid,
    output logic                               o_local_ready,
    output logic                               o_local_afull,
    output logic [OFFSET_PKT_STRUCT_WIDTH-1:0] o_offset_pkt_to_ring,
    output logic [GCID_WIDTH-1:0]              o_gcid_to_ring,
    output logic [NODE_ID_WIDTH-1:0]           o_node_id_to_ring,
    output logic [NB_CELL_COUNT_WIDTH-1:0]     o_lifetime_to_ring,
    output logic [POS_PKT_STRUCT_WIDTH-1:0]    o_pos_pkt_to_pe,
    output logic [NODE_ID_WIDTH-1:0]           o_node_id_to_pe,
    output logic                               o_pos_pkt_to_pe_valid,
    input  logic                               i_pe_ready,
    output logic [15:0]                        o_hit_stall_cnt,
    output logic                               o_node_empty
);

    localparam int LAW         = $clog2(LOCAL_FIFO_DEPTH);
    localparam int PAW         = $clog2(PE_FIFO_DEPTH);
    localparam int PE_WIDTH    = POS_PKT_STRUCT_WIDTH + NODE_ID_WIDTH;
    localparam int c_afull_lvl = (LOCAL_AFULL_MARGIN >= LOCAL_FIFO_DEPTH) ? 0
                                 : LOCAL_FIFO_DEPTH - LOCAL_AFULL_MARGIN;

    pos_ring_slot_t                     r_ring;
    logic [15:0]                        r_stall_cnt;
    pos_ring_slot_t                     w_ring_nxt;
    pos_ring_slot_t                     w_local_in;
    logic [POS_RING_SLOT_WIDTH-1:0]     w_local_head;
    logic                               w_local_full, w_local_empty, w_local_pop;
    logic [LAW:0]                       w_local_count;
    logic [PE_WIDTH-1:0]                w_pe_in, w_pe_head;
    logic                               w_pe_full, w_pe_empty, w_pe_pop, w_pe_push;
    logic [PAW:0]                       w_pe_count;
    logic                               w_slot_valid, w_hit, w_stall, w_slot_free;
    logic [GCID_WIDTH-1:0]              w_cid;
    logic [NB_CELL_COUNT_WIDTH-1:0]     w_fwd_lifetime;

    // Lowest-numbered matching fold supplies the neighbour cid.
    always_comb begin
        w_hit = 1'b0;
        w_cid = '0;
        for (int f = NUM_CELL_FOLDS - 1; f >= 0; f--) begin
            if (check_pos_input_ring_target_hit(i_source_gcid, GCELL_X[f], GCELL_Y[f], GCELL_Z[f])) begin
                w_hit = 1'b1;
                w_cid = compute_nb_cid(i_source_gcid, GCELL_X[f], GCELL_Y[f], GCELL_Z[f]);
            end
        end
    end

    assign w_slot_valid   = (i_source_lifetime != '0);
    assign w_pe_pop       = !w_pe_empty && i_pe_ready;
    assign w_pe_push      = w_slot_valid && w_hit && (!w_pe_full || w_pe_pop);
    assign w_stall        = w_slot_valid && w_hit && !w_pe_push;
    assign w_fwd_lifetime = w_pe_push ? (i_source_lifetime - NB_CELL_COUNT_WIDTH'(1))
                                      : i_source_lifetime;
    assign w_slot_free    = (w_fwd_lifetime == '0);
    assign w_local_pop    = w_slot_free && !w_local_empty;
    assign w_pe_in        = {w_cid, i_source_offset_pkt, i_source_node_id};
    assign w_local_in     = '{offset_pkt: i_local_offset_pkt, gcid: i_local_gcid,
                              node_id: i_local_node_id, lifetime: i_local_lifetime};

    always_comb begin
        w_ring_nxt          = r_ring;
        w_ring_nxt.lifetime = '0;
        if (!w_slot_free) begin
            w_ring_nxt = '{offset_pkt: i_source_offset_pkt, gcid: i_source_gcid,
                           node_id: i_source_node_id, lifetime: w_fwd_lifetime};
        end else if (w_local_pop) begin
            w_ring_nxt = pos_ring_slot_t'(w_local_head);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ring      <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_ring <= w_ring_nxt;
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    md_sync_fifo #(.WIDTH(POS_RING_SLOT_WIDTH), .DEPTH(LOCAL_FIFO_DEPTH)) u_local_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (i_local_valid),
        .i_push_data(w_local_in),
        .i_pop      (w_local_pop),
        .o_head     (w_local_head),
        .o_full     (w_local_full),
        .o_empty    (w_local_empty),
        .o_count    (w_local_count)
    );

    md_sync_fifo #(.WIDTH(PE_WIDTH), .DEPTH(PE_FIFO_DEPTH)) u_pe_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_pe_push),
        .i_push_data(w_pe_in),
        .i_pop      (w_pe_pop),
        .o_head     (w_pe_head),
        .o_full     (w_pe_full),
        .o_empty    (w_pe_empty),
        .o_count    (w_pe_count)
    );

    assign o_local_ready         = !w_local_full;
    assign o_local_afull         = (32'(w_local_count) >= c_afull_lvl);
    assign o_offset_pkt_to_ring  = r_ring.offset_pkt;
    assign o_gcid_to_ring        = r_ring.gcid;
    assign o_node_id_to_ring     = r_ring.node_id;
    assign o_lifetime_to_ring    = r_ring.lifetime;
    assign o_pos_pkt_to_pe_valid = !w_pe_empty;
    // Head is blanked while empty so the PE never sees stale payload.
    assign o_pos_pkt_to_pe       = w_pe_empty ? '0 : w_pe_head[PE_WIDTH-1:NODE_ID_WIDTH];
    assign o_node_id_to_pe       = w_pe_empty ? '0 : w_pe_head[NODE_ID_WIDTH-1:0];
    assign o_hit_stall_cnt       = r_stall_cnt;
    assign o_node_empty          = !w_slot_valid && w_local_empty && (w_pe_count == '0) &&
                                   (r_ring.lifetime == '0);

endmodule

`default_nettype wire

// File: doc/pos_input_ring_node_buf.md
# pos_input_ring_node_buf

Buffered, parametrised position-input ring node. It sits between the position cache and the position-input ring, one per PE group, and replaces the unbuffered node. It delivers ring packets that hit this node's folded cells to the PE through an output FIFO with a valid/ready handshake, and decrements their lifetime. It injects locally produced packets from an input FIFO into free ring slots, so it no longer relies on external back-pressure timing.

## Interface
- NUM_FOLDS, NUM_CELL_FOLDS: number of home cells folded onto this node.
- GCELL_X / GCELL_Y / GCELL_Z, '{3'h0}: per-fold global cell coordinates, GLOBAL_CELL_ID_WIDTH each.
- LOCAL_FIFO_DEPTH, 8: local injection FIFO entries, power of two, ≥2.
- PE_FIFO_DEPTH, 4: PE delivery FIFO entries, power of two, ≥2.
- LOCAL_AFULL_MARGIN, 2: free-entry threshold for o_local_afull.
- clk  in  1  ring clock.
- rst  in  1  asynchronous, active-low reset.
- i_source_offset_pkt  in  OFFSET_PKT_STRUCT_WIDTH  ring payload from the previous node.
- i_source_gcid  in  3*GLOBAL_CELL_ID_WIDTH  source global cell id {z,y,x}.
- i_source_node_id  in  NODE_ID_WIDTH  originating node.
- i_source_lifetime  in  NB_CELL_COUNT_WIDTH  remaining deliveries; non-zero means the slot is valid.
- i_local_offset_pkt / i_local_gcid / i_local_node_id / i_local_lifetime  in  as source fields  packet from the position cache.
- i_local_valid  in  1  local push request.
- o_local_ready  out  1  local FIFO not full.
- o_local_afull  out  1  free entries ≤ LOCAL_AFULL_MARGIN.
- o_offset_pkt_to_ring / o_gcid_to_ring / o_node_id_to_ring / o_lifetime_to_ring  out  as source fields  registered ring output.
- o_pos_pkt_to_pe  out  POS_PKT_STRUCT_WIDTH  {cid_z, cid_y, cid_x, offset_pkt}.
- o_node_id_to_pe  out  NODE_ID_WIDTH  originating node of the PE packet.
- o_pos_pkt_to_pe_valid  out  1  PE FIFO head valid.
- i_pe_ready  in  1  PE accepts the head.
- o_hit_stall_cnt  out  16  saturating count of hits deferred because the PE FIFO was full.
- o_node_empty  out  1  ring input slot empty, both FIFOs empty, ring output register empty.

## Operation
- Slot valid: i_source_lifetime != 0. Hit and neighbour cid come from check_pos_input_ring_target_hit and compute_nb_cid on i_source_gcid.
- Valid hit with PE FIFO not full, or full and popping this cycle:
  - push {cid, offset_pkt} and node_id into the PE FIFO;
  - forwarded lifetime = i_source_lifetime − 1;
  - slot is free when the result is 0.
- Valid hit with PE FIFO full and not popping: forward the packet unchanged (it recirculates the ring) and increment o_hit_stall_cnt, which saturates at 16'hFFFF.
- Valid miss: forward unchanged.
- Free slot (input invalid or consumed to 0) with local FIFO non-empty: pop the head and place it on the ring output. Injected packets are never delivered at this node.
- Free slot with the local FIFO empty: ring output lifetime = 0, and the other ring fields hold their previous values.
- Local push with o_local_ready=0 is ignored (dropped). The producer must honour ready.
- Simultaneous push and pop on a full local FIFO: the pop frees the entry and the push is accepted the same cycle. On an empty FIFO the pushed entry is popped no earlier than the next cycle.
- Lifetime arithmetic is NB_CELL_COUNT_WIDTH unsigned. Decrement occurs only when the value is non-zero, so there is no wrap.

## Timing
- Ring path: one-register latency. Inputs at cycle n appear on o_*_to_ring at cycle n+1.
- PE path: a hit at cycle n gives o_pos_pkt_to_pe_valid at n+1 at the earliest. The head holds stable while valid && !i_pe_ready.
- Local path: a push at n is injectable at n+1 at the earliest, so ring output appears at n+2.
- Reset (rst=0, asynchronous):
  - all ring outputs 0, PE outputs 0, o_hit_stall_cnt 0;
  - FIFO pointers cleared, o_local_ready=1, o_local_afull=0, o_node_empty=1.
- Reset asserted mid-operation discards all FIFO contents and the ring register. There is no partial flush.

## Structure
- MD_pkg holds the existing width constants and a new pos_ring_slot_t struct {offset_pkt, gcid, node_id, lifetime}.
- Sub-module md_sync_fifo (parametrised WIDTH, DEPTH; push/pop/full/empty/count; asynchronous active-low reset) is instantiated twice.
- Reuse the existing check_pos_input_ring_target_hit and compute_nb_cid unchanged.

## Test plan
- Hit with lifetime 3, PE ready: one PE packet with correct cid at n+1, ring lifetime 2 at n+1.
- Hit with lifetime 1 and local FIFO holding one packet of lifetime 5: PE packet delivered, and the ring output at n+1 is the local packet with lifetime 5.
- i_pe_ready=0, four hits fill the PE FIFO, a fifth hit arrives: it forwards unchanged, o_hit_stall_cnt=1, and the PE head stays stable.
- Push 8 local packets with a continuously busy ring (all misses): o_local_ready=0 after the 8th, o_local_afull asserted at 6 entries, no injection occurs.
- Miss with lifetime 4: forwarded unchanged with lifetime 4, no PE valid.
- Assert rst mid-traffic with both FIFOs partly full: all outputs 0 immediately, o_node_empty=1, and the first post-reset push is accepted.
